multi_dds_rom_ctrl: RTL
=======================

MULTI_DDS_ROM_CTRL -- requirements
Module: multi_dds_rom_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 4, channel count, 1..8.
REQ-002 SHALL have parameter PHASE_W, default 16, phase accumulator width, >= ADDR_W+2.
REQ-003 SHALL have parameter ADDR_W, default 12, quarter-wave ROM address width.
REQ-004 SHALL have parameter DATA_W, default 7, ROM magnitude width (unsigned).
REQ-005 SHALL have parameter ROM_LAT, default 1, external ROM read latency in cycles, 1 or 2.
REQ-006 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-007 SHALL have port tb_rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port run  input  1  level; 1 = generate samples.
REQ-009 SHALL have port phase_clr  input  1  pulse; zero all accumulators.
REQ-010 SHALL have port ch_en  input  N_CH  per-channel enable.
REQ-011 SHALL have port inc_wr  input  1  increment write strobe.
REQ-012 SHALL have port ch_sel  input  3  channel index for inc_wr.
REQ-013 SHALL have port inc_data  input  PHASE_W  phase increment value.
REQ-014 SHALL have port rom_addr  output  ADDR_W  address to external ROM.
REQ-015 SHALL have port rom_rd_data  input  DATA_W  ROM read data, valid ROM_LAT cycles after rom_addr.
REQ-016 SHALL have port sample  output  DATA_W+1  signed two's-complement sample.
REQ-017 SHALL have port sample_ch  output  3  channel tag of sample.
REQ-018 SHALL have port sample_valid  output  1  sample/sample_ch qualifier, one-cycle per sample.
REQ-019 SHALL have port frame_done  output  1  one-cycle pulse when slot N_CH-1 is issued.
REQ-020 SHALL have port busy  output  1  high in RUN or DRAIN or while pipeline non-empty.

Function
REQ-021 SHALL implement FSM IDLE, RUN, DRAIN: IDLE->RUN on run=1; RUN->DRAIN on run=0; DRAIN->IDLE after slot N_CH-1 issued; DRAIN->RUN not allowed until IDLE reached.
REQ-022 SHALL, in RUN/DRAIN, advance slot counter 0..N_CH-1 one per cycle, wrapping to 0; slot counter reset to 0 on entering IDLE.
REQ-023 SHALL, per slot s with ch_en[s]=1, drive rom_addr from current phase_acc[s] then update phase_acc[s] <= phase_acc[s]+inc[s] mod 2^PHASE_W.
REQ-024 SHALL, for slot s with ch_en[s]=0, hold phase_acc[s], hold rom_addr, and produce no sample_valid for that slot.
REQ-025 SHALL fold quadrant q=phase[PHASE_W-1:PHASE_W-2], idx=next ADDR_W bits: q0 addr=idx +; q1 addr=~idx +; q2 addr=idx -; q3 addr=~idx -.
REQ-026 SHALL delay sign, channel tag and issue-valid ROM_LAT cycles, then register sample = sign ? -{0,rom_rd_data} : {0,rom_rd_data}; latency issue->sample_valid = ROM_LAT+1 cycles.
REQ-027 SHALL accept inc_wr in any state; ch_sel >= N_CH ignored; write and issue of same channel same cycle: update uses old increment, new one from next issue.
REQ-028 SHALL apply phase_clr only in IDLE; ignored in RUN/DRAIN.
REQ-029 SHALL hold sample and sample_ch at last values when sample_valid=0.
REQ-030 SHALL wrap accumulator silently: 0x0001+0xFFFF -> 0x0000 (PHASE_W=16).

Reset
REQ-031 SHALL, on tb_rst=1, immediately set state IDLE, slot 0, all phase_acc and inc to 0, rom_addr 0, sample 0, sample_ch 0, sample_valid 0, frame_done 0, busy 0, pipeline flushed.
REQ-032 SHALL, on reset mid-run, emit no further sample_valid for in-flight reads.

Verification (N_CH=4, PHASE_W=16, ADDR_W=12, DATA_W=7, ROM_LAT=1, ROM model returns 7'h7F)
REQ-033 SHALL cover: release reset, run=0 -> sample_valid=0, rom_addr=0, busy=0, sample=0.
REQ-034 SHALL cover: inc[0]=0x0010, ch_en=4'b0001, run=1 -> rom_addr 0x000 then 0x004 every 4 cycles; sample=+127 ch0 two cycles after each issue.
REQ-035 SHALL cover: inc[1]=0x4000, ch_en=4'b0010 -> rom_addr 0x000,0xFFF,0x000,0xFFF; samples +127,+127,-127,-127.
REQ-036 SHALL cover: ch_en=4'b0101, all inc=0x0100 -> valid only for ch0, ch2; frame_done every 4th cycle.
REQ-037 SHALL cover: run dropped during slot 1 -> slots 2,3 still issued, busy falls 2 cycles after slot 3 issue; inc_wr with ch_sel=5 -> no register change.
REQ-038 SHALL cover: tb_rst pulsed mid-run -> sample_valid 0 without clock edge; next run starts at slot 0, rom_addr 0x000.

Source files
------------

// File: rtl/multi_dds_rom_ctrl.sv
// Time-multiplexed DDS: N_CH phase accumulators share one quarter-wave ROM port;
// ROM magnitudes are unfolded into signed full-wave samples tagged by channel.
module multi_dds_rom_ctrl #(
  parameter int N_CH    = 4,
  parameter int PHASE_W = 16,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 7,
  parameter int ROM_LAT = 1
) (
  input  logic               clk,
  input  logic               tb_rst,
  input  logic               run,
  input  logic               phase_clr,
  input  logic [N_CH-1:0]    ch_en,
  input  logic               inc_wr,
  input  logic [2:0]         ch_sel,
  input  logic [PHASE_W-1:0] inc_data,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_rd_data,
  output logic [DATA_W:0]    sample,
  output logic [2:0]         sample_ch,
  output logic               sample_valid,
  output logic               frame_done,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] LAST_SLOT = 3'(N_CH - 1);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [2:0]         slot_r;
  logic [PHASE_W-1:0] phase_acc_r [N_CH];
  logic [PHASE_W-1:0] inc_r [N_CH];
  logic [ROM_LAT:0]   vld_d_r;
  logic [ROM_LAT:0]   sgn_d_r;
  logic [2:0]         ch_d_r [ROM_LAT+1];

  logic               active_s;
  logic               issue_s;
  logic               last_slot_s;
  logic               cur_en_s;
  logic [PHASE_W-1:0] cur_phase_s;
  logic [ROM_LAT:0]   vld_nxt_s;
  logic               busy_nxt_s;

  // Quadrant fold: odd quadrants run the table backwards.
  function automatic logic [ADDR_W-1:0] fold_addr(input logic [PHASE_W-1:0] ph);
    logic [ADDR_W-1:0] idx;
    idx = ph[PHASE_W-3 -: ADDR_W];
    return ph[PHASE_W-2] ? ~idx : idx;
  endfunction

  // State register
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; DRAIN always finishes the frame before returning to IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = run ? ST_RUN : ST_IDLE;
      ST_RUN:   state_nxt_s = run ? ST_RUN : ST_DRAIN;
      ST_DRAIN: state_nxt_s = last_slot_s ? ST_IDLE : ST_DRAIN;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Current-slot channel selection and issue qualification
  always_comb begin
    cur_phase_s = '0;
    cur_en_s    = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      cur_phase_s = (slot_r == 3'(c)) ? phase_acc_r[c] : cur_phase_s;
      cur_en_s    = (slot_r == 3'(c)) ? ch_en[c] : cur_en_s;
    end
    active_s    = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    last_slot_s = (slot_r == LAST_SLOT);
    issue_s     = active_s && cur_en_s;
    vld_nxt_s   = {vld_d_r[ROM_LAT-1:0], issue_s};
    busy_nxt_s  = (state_nxt_s != ST_IDLE) || (|vld_nxt_s);
  end

  // Slot counter
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      slot_r <= 3'd0;
    end else if (state_nxt_s == ST_IDLE) begin
      slot_r <= 3'd0;
    end else if (active_s) begin
      slot_r <= last_slot_s ? 3'd0 : slot_r + 3'd1;
    end
  end

  // Phase accumulators; clearing is honoured only while idle
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      for (int c = 0; c < N_CH; c++) begin
        phase_acc_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if ((state_r == ST_IDLE) && phase_clr) begin
          phase_acc_r[c] <= '0;
        end else if (issue_s && (slot_r == 3'(c))) begin
          phase_acc_r[c] <= phase_acc_r[c] + inc_r[c];
        end
      end
    end
  end

  // Increment registers; out-of-range channel indices match no entry
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      for (int c = 0; c < N_CH; c++) begin
        inc_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (inc_wr && (ch_sel == 3'(c))) begin
          inc_r[c] <= inc_data;
        end
      end
    end
  end

  // ROM address issue, tag/sign delay line and status flags
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      rom_addr   <= '0;
      vld_d_r    <= '0;
      sgn_d_r    <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      for (int k = 0; k <= ROM_LAT; k++) begin
        ch_d_r[k] <= 3'd0;
      end
    end else begin
      if (issue_s) begin
        rom_addr <= fold_addr(cur_phase_s);
      end
      vld_d_r    <= vld_nxt_s;
      sgn_d_r    <= {sgn_d_r[ROM_LAT-1:0], cur_phase_s[PHASE_W-1]};
      ch_d_r[0]  <= slot_r;
      for (int k = 1; k <= ROM_LAT; k++) begin
        ch_d_r[k] <= ch_d_r[k-1];
      end
      frame_done <= active_s && last_slot_s;
      busy       <= busy_nxt_s;
    end
  end

  // Sample output: the sign applies to the zero-extended ROM magnitude
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      sample       <= '0;
      sample_ch    <= 3'd0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= vld_d_r[ROM_LAT];
      if (vld_d_r[ROM_LAT]) begin
        sample    <= sgn_d_r[ROM_LAT] ? -{1'b0, rom_rd_data} : {1'b0, rom_rd_data};
        sample_ch <= ch_d_r[ROM_LAT];
      end
    end
  end

endmodule
